// File: rtl/dm_ctrl.sv
// Handshaked data memory: byte/half/word loads and stores with configurable latency,
// alignment/range checking and a post-reset clearing sweep.
module dm_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 1,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        init_done
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned HI_LSB = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_cnt_n;
    logic [CNT_W-1:0]      lat_cnt, lat_cnt_n;
    logic [31:0]           mem [DEPTH];

    logic        r_we, r_sext;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    logic        req_ready_n, resp_valid_n, init_done_n, resp_err_n;
    logic [31:0] resp_rdata_n;
    logic        accept_c, commit_c, sweep_we_c;

    logic                  op_we, op_sext;
    logic [1:0]            op_size;
    logic [31:0]           op_addr, op_wdata;
    logic [ADDR_WIDTH-1:0] idx_c;
    logic [1:0]            lane_c;
    logic                  err_c;
    logic [31:0]           old_c, store_c, load_c;
    logic [7:0]            byte_c;
    logic [15:0]           half_c;

    // With LATENCY==1 the commit edge is also the accept edge, so the live request is used.
    always_comb begin
        if (state == IDLE) begin
            op_we    = req_we;
            op_size  = req_size;
            op_sext  = req_sext;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end else begin
            op_we    = r_we;
            op_size  = r_size;
            op_sext  = r_sext;
            op_addr  = r_addr;
            op_wdata = r_wdata;
        end
    end

    // Address decode, error check, store merge and load extraction for the committing request.
    always_comb begin
        idx_c  = op_addr[ADDR_WIDTH+1:2];
        lane_c = op_addr[1:0];
        err_c  = (op_size == 2'b11)
               || ((op_size == 2'b01) && op_addr[0])
               || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
               || ((op_addr >> HI_LSB) != 32'h0);
        old_c  = mem[idx_c];
        byte_c = old_c[{lane_c, 3'b000} +: 8];
        half_c = old_c[{op_addr[1], 4'b0000} +: 16];

        store_c = old_c;
        case (op_size)
            2'b00:   store_c[{lane_c, 3'b000} +: 8]       = op_wdata[7:0];
            2'b01:   store_c[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
            default: store_c = op_wdata;
        endcase

        case (op_size)
            2'b00:   load_c = {{24{op_sext & byte_c[7]}}, byte_c};
            2'b01:   load_c = {{16{op_sext & half_c[15]}}, half_c};
            default: load_c = old_c;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        sweep_cnt_n  = sweep_cnt;
        lat_cnt_n    = lat_cnt;
        accept_c     = 1'b0;
        commit_c     = 1'b0;
        sweep_we_c   = 1'b0;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;

        case (state)
            CLEAR: begin
                sweep_we_c  = 1'b1;
                sweep_cnt_n = sweep_cnt + ADDR_WIDTH'(1);
                if (sweep_cnt == ADDR_WIDTH'(DEPTH - 1)) state_n = IDLE;
            end
            IDLE: begin
                if (req_valid) begin
                    accept_c  = 1'b1;
                    lat_cnt_n = CNT_W'(LATENCY);
                    if (LATENCY > 1) begin
                        state_n = WAIT;
                    end else begin
                        state_n  = RESP;
                        commit_c = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == CNT_W'(1)) begin
                    state_n  = RESP;
                    commit_c = 1'b1;
                end else begin
                    lat_cnt_n = lat_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = CLEAR;
        endcase

        if (commit_c) begin
            resp_err_n   = err_c;
            resp_rdata_n = (err_c || op_we) ? 32'h0 : load_c;
        end

        req_ready_n  = (state_n == IDLE);
        resp_valid_n = (state_n == RESP);
        init_done_n  = (state_n != CLEAR);
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            sweep_cnt  <= '0;
            lat_cnt    <= '0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_sext     <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_n;
            sweep_cnt  <= sweep_cnt_n;
            lat_cnt    <= lat_cnt_n;
            if (accept_c) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_sext  <= req_sext;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
            init_done  <= init_done_n;
        end
    end

    // Storage: sweep writes, then committed non-error stores; reset blocks any pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sweep_we_c) begin
                mem[sweep_cnt] <= INIT_VALUE;
            end else if (commit_c && op_we && !err_c) begin
                mem[idx_c] <= store_c;
            end
        end
    end

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: directed cases plus randomized traffic checked
// against an arithmetic memory model.
module tb_dm_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 3;
    localparam logic [31:0] INIT  = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err, init_done;
    logic [31:0] resp_rdata;

    dm_ctrl #(.ADDR_WIDTH(AW), .LATENCY(LAT), .INIT_VALUE(INIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sext   (req_sext),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned acc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mdl [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          seen_valid = 1'b0;
    bit          bp_mode    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference behaviour: word-array memory with shift/mask arithmetic on byte addresses.
    function automatic exp_t model(input bit we, input logic [1:0] size, input bit sext,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int unsigned a, sh;
        logic [31:0] w, mask, v;
        a = addr;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.acc   = 0;
        if (size == 2'd3 || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0)
            || a >= 4 * DEPTH) begin
            e.err = 1'b1;
            return e;
        end
        w = mdl[a / 4];
        if (size == 2'd1) begin
            sh = 16 * ((a / 2) % 2);
            mask = 32'h0000_FFFF;
        end else begin
            sh = 8 * (a % 4);
            mask = 32'h0000_00FF;
        end
        if (we) begin
            if (size == 2'd2) mdl[a / 4] = wdata;
            else mdl[a / 4] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        end else if (size == 2'd2) begin
            e.rdata = w;
        end else begin
            v = (w >> sh) & mask;
            if (sext && v > (mask >> 1)) v = v | ~mask;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(input bit we, input logic [1:0] size, input bit sext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int   waited = 0;
        exp_t e;
        while (req_ready !== 1'b1 && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (req_ready !== 1'b1) begin
            chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
            return;
        end
        req_we = we; req_size = size; req_sext = sext; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_sext = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        e = model(we, size, sext, addr, wdata);
        e.acc = cyc;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_init_done", {31'h0, init_done}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = INIT;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            chk("sweep_init_done", {31'h0, init_done}, (i == DEPTH) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sbq.size() != 0 && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("drain_timeout", sbq.size(), 32'h0);
    endtask

    // Monitor: compare the presented response against the scoreboard head every cycle it is valid.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                seen_valid = 1'b0;
                continue;
            end
            if (resp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
                end else begin
                    if (!seen_valid) begin
                        chk("latency", cyc - sbq[0].acc, LAT);
                        seen_valid = 1'b1;
                    end
                    chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
                    chk("rdata", resp_rdata, sbq[0].rdata);
                    chk("err", {31'h0, resp_err}, {31'h0, sbq[0].err});
                    if (resp_ready) begin
                        void'(sbq.pop_front());
                        seen_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Random consumer backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_mode) resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int          waited;
        logic [31:0] ra;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sext = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

        do_reset();
        issue(0, 2'd2, 0, 32'h3C, 32'h0);

        issue(1, 2'd2, 0, 32'h8, 32'h1234_5678);
        issue(0, 2'd0, 1, 32'hB, 32'h0);
        issue(1, 2'd0, 0, 32'h9, 32'hFFFF_FF80);
        issue(0, 2'd0, 1, 32'h9, 32'h0);
        issue(0, 2'd0, 0, 32'h9, 32'h0);
        issue(0, 2'd2, 0, 32'h8, 32'h0);
        drain();

        // Half store, then a half load held under backpressure for three cycles.
        issue(1, 2'd1, 0, 32'h6, 32'h1234_BEEF);
        issue(0, 2'd1, 1, 32'h6, 32'h0);
        resp_ready = 1'b0;
        waited = 0;
        while (resp_valid !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("stall_resp_arrives", {31'h0, resp_valid}, 32'h1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_valid_held", {31'h0, resp_valid}, 32'h1);
        end
        resp_ready = 1'b1;
        drain();

        // Error cases must neither write nor return data.
        issue(1, 2'd2, 0, 32'h0, 32'h1122_3344);
        issue(0, 2'd2, 0, 32'h2, 32'h0);
        issue(1, 2'd1, 0, 32'h1, 32'h0000_FFFF);
        issue(0, 2'd3, 0, 32'h0, 32'h0);
        issue(0, 2'd2, 0, 32'h40, 32'h0);
        issue(1, 2'd2, 0, 32'h8000_0000, 32'h5555_AAAA);
        issue(1, 2'd0, 0, 32'h40, 32'h0000_0077);
        issue(0, 2'd2, 0, 32'h0, 32'h0);
        drain();

        // Randomized traffic with random backpressure.
        bp_mode = 1'b1;
        repeat (300) begin
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1));
            issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom);
        end
        drain();
        bp_mode = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b1;

        // Reset while a store is in WAIT: the store must never land.
        issue(1, 2'd2, 0, 32'h4, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        do_reset();
        issue(0, 2'd2, 0, 32'h4, 32'h0);
        issue(0, 2'd2, 0, 32'h8, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
